// File: rtl/cpu_mem_map.sv
// NES CPU-side memory map: work RAM, PPU and IO register windows, PRG ROM
// mirroring, and the $4014 OAM DMA engine that stalls the CPU for one page copy.
`timescale 1ns/1ps
module cpu_mem_map #(
  parameter int RAM_ADDR_W = 11,
  parameter int PRG_ADDR_W = 15,
  parameter int DMA_ALIGN  = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clock_en,
  input  logic [15:0]           addr,
  input  logic                  r_en,
  input  logic [7:0]            w_data,
  output logic [7:0]            r_data,
  output logic                  cpu_stall,
  output logic                  ppu_reg_en,
  output logic [2:0]            ppu_reg_sel,
  output logic                  ppu_reg_rw,
  output logic [7:0]            ppu_reg_wdata,
  input  logic [7:0]            ppu_reg_rdata,
  output logic [PRG_ADDR_W-1:0] prg_addr,
  input  logic [7:0]            prg_rdata
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HALT  = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam int RAM_DEPTH = 1 << RAM_ADDR_W;

  logic [2:0]  state;
  logic        parity;
  logic [7:0]  dma_page;
  logic [7:0]  dma_idx;
  logic [7:0]  dma_buf;
  logic [7:0]  ram [RAM_DEPTH];
  logic [7:0]  io_regs [32];
  logic [15:0] ea;
  logic        idle;
  logic        dma_rd;
  logic        ram_hit;
  logic        ppu_hit;
  logic        io_hit;
  logic        dma_hit;
  logic        prg_hit;
  logic        cpu_wr;
  logic [7:0]  rd_mux;

  // During a DMA read cycle the engine drives the bus instead of the CPU.
  assign idle    = (state == IDLE);
  assign dma_rd  = (state == READ);
  assign ea      = dma_rd ? {dma_page, dma_idx} : addr;
  assign ram_hit = (ea[15:13] == 3'b000);
  assign ppu_hit = (ea[15:13] == 3'b001);
  assign io_hit  = (ea[15:5] == 11'h200);
  assign dma_hit = (ea == 16'h4014);
  assign prg_hit = ea[15];
  assign cpu_wr  = clock_en && idle && !r_en;

  assign cpu_stall = !idle;
  assign prg_addr  = ea[PRG_ADDR_W-1:0];

  always_comb begin
    rd_mux = 8'h00;
    if (ram_hit)      rd_mux = ram[ea[RAM_ADDR_W-1:0]];
    else if (ppu_hit) rd_mux = ppu_reg_rdata;
    else if (dma_hit) rd_mux = dma_page;
    else if (io_hit)  rd_mux = io_regs[ea[4:0]];
    else if (prg_hit) rd_mux = prg_rdata;
    else              rd_mux = 8'h00;
  end

  always_comb begin
    ppu_reg_en    = 1'b0;
    ppu_reg_sel   = ea[2:0];
    ppu_reg_rw    = 1'b1;
    ppu_reg_wdata = w_data;
    if (state == WRITE) begin
      ppu_reg_en    = clock_en;
      ppu_reg_sel   = 3'd4;
      ppu_reg_rw    = 1'b0;
      ppu_reg_wdata = dma_buf;
    end else if (idle || dma_rd) begin
      ppu_reg_en = clock_en && ppu_hit;
      ppu_reg_rw = dma_rd ? 1'b1 : r_en;
    end else begin
      ppu_reg_en = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      parity   <= 1'b0;
      dma_page <= 8'h00;
      dma_idx  <= 8'h00;
      dma_buf  <= 8'h00;
      r_data   <= 8'h00;
    end else if (clock_en) begin
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (!r_en && dma_hit) begin
            state    <= HALT;
            dma_page <= w_data;
            dma_idx  <= 8'h00;
          end
        end
        // The alignment stall lands the first READ on a consistent parity.
        HALT:  state <= ((DMA_ALIGN != 0) && !parity) ? ALIGN : READ;
        ALIGN: state <= READ;
        READ: begin
          dma_buf <= rd_mux;
          state   <= WRITE;
        end
        WRITE: begin
          if (dma_idx == 8'hFF) begin
            state <= IDLE;
          end else begin
            dma_idx <= dma_idx + 8'd1;
            state   <= READ;
          end
        end
        default: state <= IDLE;
      endcase
      if (idle && r_en) r_data <= rd_mux;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= 8'h00;
      for (int j = 0; j < 32; j++) io_regs[j] <= 8'h00;
    end else if (cpu_wr) begin
      if (ram_hit)                 ram[ea[RAM_ADDR_W-1:0]] <= w_data;
      else if (io_hit && !dma_hit) io_regs[ea[4:0]] <= w_data;
    end
  end
endmodule

// File: tb/tb_cpu_mem_map.sv
// Bench for cpu_mem_map: decode vectors plus OAM DMA timing/ordering/reset
// sequences on an aligned instance and a DMA_ALIGN=0 instance.
`timescale 1ns/1ps
module tb_cpu_mem_map;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clock_en = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic        r_en = 1'b1;
  logic [7:0]  w_data = 8'h00;
  logic [7:0]  ppu_reg_rdata = 8'h00;

  logic [7:0]  r_data, r_data_n, ppu_reg_wdata, ppu_reg_wdata_n, prg_rdata, prg_rdata_n;
  logic        cpu_stall, cpu_stall_n, ppu_reg_en, ppu_reg_en_n, ppu_reg_rw, ppu_reg_rw_n;
  logic [2:0]  ppu_reg_sel, ppu_reg_sel_n;
  logic [13:0] prg_addr;
  logic [14:0] prg_addr_n;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign prg_rdata   = prg_addr[7:0] ^ 8'h5A;
  assign prg_rdata_n = prg_addr_n[7:0] ^ 8'h5A;

  cpu_mem_map #(.RAM_ADDR_W(11), .PRG_ADDR_W(14), .DMA_ALIGN(1)) dut (
    .clock(clock), .reset_n(reset_n), .clock_en(clock_en), .addr(addr), .r_en(r_en),
    .w_data(w_data), .r_data(r_data), .cpu_stall(cpu_stall), .ppu_reg_en(ppu_reg_en),
    .ppu_reg_sel(ppu_reg_sel), .ppu_reg_rw(ppu_reg_rw), .ppu_reg_wdata(ppu_reg_wdata),
    .ppu_reg_rdata(ppu_reg_rdata), .prg_addr(prg_addr), .prg_rdata(prg_rdata));

  cpu_mem_map #(.RAM_ADDR_W(11), .PRG_ADDR_W(15), .DMA_ALIGN(0)) dut_na (
    .clock(clock), .reset_n(reset_n), .clock_en(clock_en), .addr(addr), .r_en(r_en),
    .w_data(w_data), .r_data(r_data_n), .cpu_stall(cpu_stall_n), .ppu_reg_en(ppu_reg_en_n),
    .ppu_reg_sel(ppu_reg_sel_n), .ppu_reg_rw(ppu_reg_rw_n), .ppu_reg_wdata(ppu_reg_wdata_n),
    .ppu_reg_rdata(ppu_reg_rdata), .prg_addr(prg_addr_n), .prg_rdata(prg_rdata_n));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference parity: toggles on every enabled cycle since reset.
  logic par;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) par <= 1'b0;
    else if (clock_en) par <= ~par;
  end

  logic [7:0] oam_q[$];
  logic [7:0] sb_q[$];
  int oam_writes = 0;
  int stall_a = 0;
  int stall_n = 0;
  int ppu_en_seen = 0;

  // Mid-cycle monitor: stall lengths and the OAMDATA write stream.
  always @(negedge clock) begin
    if (cpu_stall) stall_a++;
    if (cpu_stall_n) stall_n++;
    if (ppu_reg_en) ppu_en_seen++;
    if (reset_n && clock_en && ppu_reg_en && ppu_reg_sel == 3'd4 && !ppu_reg_rw) begin
      oam_writes++;
      if (oam_q.size() == 0) check("oam_unexpected_write", 16'(oam_q.size()), 16'd1);
      else check($sformatf("oam_data_%0d", oam_writes), {8'h00, ppu_reg_wdata}, {8'h00, oam_q.pop_front()});
    end
  end

  typedef struct {
    logic [15:0] a;
    logic        ren;
    logic [7:0]  wd;
    logic [7:0]  prd;
    logic [7:0]  exp_rd;
    logic        en;
    logic [2:0]  sel;
    logic        rw;
    logic [7:0]  pwd;
    logic        chk_prg;
    logic [13:0] prg;
  } vec_t;

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string name);
    logic [7:0] e;
    addr = a; r_en = 1'b1; w_data = 8'h00;
    sb_q.push_back(exp);
    @(posedge clock); #1;
    e = sb_q.pop_front();
    check(name, {8'h00, r_data}, {8'h00, e});
  endtask

  task automatic run_dma(input logic start_par, input int freeze_at, input int exp_a,
                         input int exp_n, input int stop_after);
    int cyc;
    if (par !== start_par) begin
      addr = 16'h4014; r_en = 1'b1;
      @(posedge clock); #1;
    end
    oam_q.delete();
    for (int i = 0; i < 256; i++) oam_q.push_back(8'(i));
    oam_writes = 0; stall_a = 0; stall_n = 0;
    addr = 16'h4014; r_en = 1'b0; w_data = 8'h02;
    @(posedge clock); #1;
    addr = 16'h0000; r_en = 1'b1; w_data = 8'h00;
    cyc = 0;
    while ((cpu_stall || cpu_stall_n) && cyc < 2000 &&
           !(stop_after > 0 && oam_writes >= stop_after)) begin
      if (cyc == freeze_at) clock_en = 1'b0;
      if (cyc == freeze_at + 5) clock_en = 1'b1;
      @(posedge clock); #1;
      cyc++;
    end
    clock_en = 1'b1;
    if (stop_after > 0) begin
      check("dma_reached_stop", 16'(oam_writes), 16'(stop_after));
    end else begin
      check("dma_finished", {15'd0, cpu_stall | cpu_stall_n}, 16'd0);
      check("dma_stall_len", 16'(stall_a), 16'(exp_a));
      check("dma_stall_len_noalign", 16'(stall_n), 16'(exp_n));
      check("dma_write_count", 16'(oam_writes), 16'd256);
      cpu_read(16'h4014, 8'h02, "dma_page_readback");
    end
  endtask

  vec_t vec[22];
  int seen_en, seen_wr;

  initial begin
    vec[0]  = '{16'h0100, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[1]  = '{16'h0005, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[2]  = '{16'h0805, 1'b1, 8'h00, 8'h00, 8'hA5, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[3]  = '{16'h1805, 1'b1, 8'h00, 8'h00, 8'hA5, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[4]  = '{16'h8000, 1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 14'h0000};
    vec[5]  = '{16'h3FFA, 1'b1, 8'h00, 8'h3C, 8'h3C, 1'b1, 3'd2, 1'b1, 8'h00, 1'b0, 14'h0000};
    vec[6]  = '{16'h2007, 1'b0, 8'h11, 8'h00, 8'h3C, 1'b1, 3'd7, 1'b0, 8'h11, 1'b0, 14'h0000};
    vec[7]  = '{16'h8123, 1'b1, 8'h00, 8'h00, 8'h79, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 14'h0123};
    vec[8]  = '{16'h0005, 1'b1, 8'h00, 8'h00, 8'hA5, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[9]  = '{16'hC123, 1'b1, 8'h00, 8'h00, 8'h79, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 14'h0123};
    vec[10] = '{16'h4000, 1'b0, 8'h3E, 8'h00, 8'h79, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[11] = '{16'h4000, 1'b1, 8'h00, 8'h00, 8'h3E, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[12] = '{16'h401F, 1'b0, 8'h77, 8'h00, 8'h3E, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[13] = '{16'h401F, 1'b1, 8'h00, 8'h00, 8'h77, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[14] = '{16'h4020, 1'b0, 8'h99, 8'h00, 8'h77, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[15] = '{16'h4020, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[16] = '{16'h0005, 1'b1, 8'h00, 8'h00, 8'hA5, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[17] = '{16'h7FFF, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[18] = '{16'h401F, 1'b1, 8'h00, 8'h00, 8'h77, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[19] = '{16'h4014, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[20] = '{16'h1FFF, 1'b0, 8'hC3, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};
    vec[21] = '{16'h07FF, 1'b1, 8'h00, 8'h00, 8'hC3, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0000};

    repeat (3) @(posedge clock);
    #1;
    check("reset_r_data", {8'h00, r_data}, 16'h0000);
    check("reset_cpu_stall", {15'd0, cpu_stall}, 16'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      logic [7:0] e;
      addr = vec[i].a; r_en = vec[i].ren; w_data = vec[i].wd; ppu_reg_rdata = vec[i].prd;
      sb_q.push_back(vec[i].exp_rd);
      #1;
      check($sformatf("v%0d_ppu_en", i), {15'd0, ppu_reg_en}, {15'd0, vec[i].en});
      if (vec[i].en) begin
        check($sformatf("v%0d_ppu_sel", i), {13'd0, ppu_reg_sel}, {13'd0, vec[i].sel});
        check($sformatf("v%0d_ppu_rw", i), {15'd0, ppu_reg_rw}, {15'd0, vec[i].rw});
        if (!vec[i].rw) check($sformatf("v%0d_ppu_wdata", i), {8'h00, ppu_reg_wdata}, {8'h00, vec[i].pwd});
      end
      if (vec[i].chk_prg) check($sformatf("v%0d_prg_addr", i), {2'b00, prg_addr}, {2'b00, vec[i].prg});
      @(posedge clock); #1;
      e = sb_q.pop_front();
      check($sformatf("v%0d_r_data", i), {8'h00, r_data}, {8'h00, e});
      check($sformatf("v%0d_r_data_noalign", i), {8'h00, r_data_n}, {8'h00, e});
    end
    ppu_reg_rdata = 8'h00;

    // Page $02 holds its own index so OAM data must be 00..FF in order.
    for (int i = 0; i < 256; i++) begin
      addr = 16'h0200 + 16'(i); r_en = 1'b0; w_data = 8'(i);
      @(posedge clock); #1;
    end
    cpu_read(16'h02A7, 8'hA7, "ram_fill_probe");

    run_dma(1'b0, -1, 513, 513, 0);
    run_dma(1'b1, -1, 514, 513, 0);
    run_dma(1'b0, 50, 518, 518, 0);

    run_dma(1'b0, -1, 0, 0, 100);
    reset_n = 1'b0;
    #1;
    check("rst_mid_dma_stall", {15'd0, cpu_stall}, 16'd0);
    check("rst_mid_dma_stall_noalign", {15'd0, cpu_stall_n}, 16'd0);
    check("rst_mid_dma_r_data", {8'h00, r_data}, 16'h0000);
    seen_en = ppu_en_seen;
    seen_wr = oam_writes;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("rst_no_ppu_en", 16'(ppu_en_seen), 16'(seen_en));
    check("rst_oam_writes", 16'(seen_wr), 16'd100);
    check("rst_stall_low", {15'd0, cpu_stall}, 16'd0);
    cpu_read(16'h0205, 8'h00, "rst_ram_cleared");
    cpu_read(16'h4014, 8'h00, "rst_dma_page_cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
